// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//
// PRBS7 (x^7 + x^6 + 1) receive checker. It hunts for alignment by loading the
// received bits into a local generator. Once enough consecutive predictions
// match, it locks and the generator free-runs from its own output. While
// locked, every valid bit is compared against the prediction. Errors are
// counted, and too many errors inside one monitoring window drop the lock.
//
// Ports
//   clk_x8      in   CDR oversampling clock; all logic on rising edge
//   rst         in   asynchronous active-high reset
//   d_in        in   recovered data bit
//   d_in_valid  in   qualifies d_in; one bit consumed per valid cycle
//   clr_counts  in   synchronous clear of err_count / bit_count
//   locked      out  checker synchronised to the stream
//   bit_err     out  one-cycle pulse per mismatched bit while locked
//   err_count   out  saturating count of errors while locked
//   bit_count   out  saturating count of bits checked while locked
//
// state  | meaning
// -------+------------------------------------------------------------
// HUNT   | generator loads received bits, counting consecutive matches
// LOCKED | generator free-runs, received bits are checked and counted
// -----------------------------------------------------------------------------
module prbs_checker #(
    parameter int unsigned LOCK_COUNT  = 32,
    parameter int unsigned LOSS_ERRS   = 8,
    parameter int unsigned LOSS_WINDOW = 128
) (
    input  logic        clk_x8,
    input  logic        rst,
    input  logic        d_in,
    input  logic        d_in_valid,
    input  logic        clr_counts,
    output logic        locked,
    output logic        bit_err,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(LOSS_WINDOW + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [6:0]    r_q, r_d;
    logic [2:0]    fill_q, fill_d;
    logic [MW-1:0] match_q, match_d;
    logic [WW-1:0] wbits_q, wbits_d;
    logic [EW-1:0] werrs_q, werrs_d;
    logic [15:0]   errc_q, errc_d;
    logic [31:0]   bitc_q, bitc_d;
    logic          locked_q, locked_d;
    logic          bit_err_q, bit_err_d;

    logic          p;
    logic          mism;
    logic          hit_lock;
    logic          hit_loss;
    logic          err_now;

    assign p    = r_q[6] ^ r_q[5];
    assign mism = (d_in != p);

    // State register
    always_ff @(posedge clk_x8 or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (hit_lock) state_d = LOCKED;
            LOCKED:  if (hit_loss) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Output logic (registered below)
    always_comb begin
        locked_d  = (state_d == LOCKED);
        bit_err_d = err_now;
    end

    // Datapath next-state
    always_comb begin
        r_d      = r_q;
        fill_d   = fill_q;
        match_d  = match_q;
        wbits_d  = wbits_q;
        werrs_d  = werrs_q;
        errc_d   = errc_q;
        bitc_d   = bitc_q;
        hit_lock = 1'b0;
        hit_loss = 1'b0;
        err_now  = 1'b0;

        if (d_in_valid) begin
            if (state_q == HUNT) begin
                r_d = {r_q[5:0], d_in};
                if (fill_q != 3'd7) begin
                    fill_d = fill_q + 3'd1;
                end
                // An all-zero register predicts zeros forever, so it never
                // counts toward lock.
                if ((r_q == 7'd0) || mism) begin
                    match_d = '0;
                end else if (fill_q == 3'd7) begin
                    match_d = match_q + MW'(1);
                    if (match_q == MW'(LOCK_COUNT - 1)) begin
                        hit_lock = 1'b1;
                    end
                end
            end else begin
                // Free-run on the prediction so a bad bit cannot corrupt
                // the generator.
                r_d     = {r_q[5:0], p};
                wbits_d = wbits_q + WW'(1);
                if (bitc_q != 32'hFFFF_FFFF) begin
                    bitc_d = bitc_q + 32'd1;
                end
                if (mism) begin
                    err_now = 1'b1;
                    werrs_d = werrs_q + EW'(1);
                    if (errc_q != 16'hFFFF) begin
                        errc_d = errc_q + 16'd1;
                    end
                end
                // Loss takes precedence over a simultaneous window rollover.
                if (mism && (werrs_q == EW'(LOSS_ERRS - 1))) begin
                    hit_loss = 1'b1;
                    fill_d   = '0;
                    match_d  = '0;
                    wbits_d  = '0;
                    werrs_d  = '0;
                end else if (wbits_q == WW'(LOSS_WINDOW - 1)) begin
                    wbits_d = '0;
                    werrs_d = '0;
                end
            end
        end

        if (clr_counts) begin
            errc_d = '0;
            bitc_d = '0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_x8 or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            wbits_q   <= '0;
            werrs_q   <= '0;
            errc_q    <= '0;
            bitc_q    <= '0;
            locked_q  <= 1'b0;
            bit_err_q <= 1'b0;
        end else begin
            r_q       <= r_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            wbits_q   <= wbits_d;
            werrs_q   <= werrs_d;
            errc_q    <= errc_d;
            bitc_q    <= bitc_d;
            locked_q  <= locked_d;
            bit_err_q <= bit_err_d;
        end
    end

    assign locked    = locked_q;
    assign bit_err   = bit_err_q;
    assign err_count = errc_q;
    assign bit_count = bitc_q;

endmodule

// File: tb/tb_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker
//
// Directed bench for prbs_checker. A behavioural PRBS7 source (seed 7'h7F)
// feeds the checker. The data path from transmitter through clock recovery is
// stood in for by the spacing of d_in_valid: either a fixed spacing or an
// irregular one that models a bit clock mismatched with clk_x8. Expected
// values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_prbs_checker;

    logic        clk_x8 = 1'b0;
    logic        rst;
    logic        d_in;
    logic        d_in_valid;
    logic        clr_counts;
    logic        locked;
    logic        bit_err;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          drops  = 0;
    int          ever   = 0;
    logic [6:0]  tx_r;

    prbs_checker #(
        .LOCK_COUNT  (32),
        .LOSS_ERRS   (8),
        .LOSS_WINDOW (128)
    ) dut (
        .clk_x8     (clk_x8),
        .rst        (rst),
        .d_in       (d_in),
        .d_in_valid (d_in_valid),
        .clr_counts (clr_counts),
        .locked     (locked),
        .bit_err    (bit_err),
        .err_count  (err_count),
        .bit_count  (bit_count)
    );

    always #5 clk_x8 = ~clk_x8;

    task automatic tick();
        @(posedge clk_x8);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One valid bit, then `gap` idle cycles. Pulses counted on the bit's edge.
    task automatic send(input logic b, input int gap);
        d_in       = b;
        d_in_valid = 1'b1;
        tick();
        d_in_valid = 1'b0;
        d_in       = 1'b0;
        if (bit_err === 1'b1) pulses++;
        repeat (gap) tick();
    endtask

    task automatic prbs(input logic inv, input int gap);
        logic b;
        b    = tx_r[6] ^ tx_r[5];
        tx_r = {tx_r[5:0], b};
        send(b ^ inv, gap);
    endtask

    initial begin
        rst        = 1'b1;
        d_in       = 1'b0;
        d_in_valid = 1'b0;
        clr_counts = 1'b0;
        tx_r       = 7'h7F;
        repeat (3) tick();
        chk("rst_locked",  locked,    0);
        chk("rst_bit_err", bit_err,   0);
        chk("rst_err_cnt", err_count, 0);
        chk("rst_bit_cnt", bit_count, 0);
        rst = 1'b0;
        tick();

        // Clean stream, one valid per 8 cycles: lock on bit 39.
        for (int i = 0; i < 38; i++) prbs(1'b0, 7);
        chk("no_lock_at_38", locked, 0);
        prbs(1'b0, 7);
        chk("lock_at_39", locked, 1);
        drops = 0;
        for (int i = 0; i < 1000; i++) begin
            prbs(1'b0, 7);
            if (locked !== 1'b1) drops++;
        end
        chk("clean_err_cnt",  err_count, 0);
        chk("clean_bit_cnt",  bit_count, 1000);
        chk("clean_no_drops", drops,     0);

        // Single inverted bit.
        prbs(1'b1, 0);
        chk("single_pulse", bit_err, 1);
        tick();
        chk("pulse_one_cycle", bit_err,   0);
        chk("single_err_cnt",  err_count, 1);
        chk("single_locked",   locked,    1);
        pulses = 0;
        // 23 more clean bits close the window at locked bit 1024.
        for (int i = 0; i < 23; i++) prbs(1'b0, 0);
        chk("single_no_more_pulses", pulses,    0);
        chk("single_err_hold",       err_count, 1);

        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        chk("clr_err_cnt", err_count, 0);
        chk("clr_bit_cnt", bit_count, 0);

        // Eight errors in a fresh window: lock lost on the eighth.
        for (int i = 0; i < 7; i++) prbs(1'b1, 0);
        chk("seven_errs_locked", locked, 1);
        prbs(1'b1, 0);
        chk("eighth_err_unlock", locked,    0);
        chk("loss_err_cnt",      err_count, 8);
        chk("loss_bit_cnt",      bit_count, 8);
        for (int i = 0; i < 38; i++) prbs(1'b0, 0);
        chk("relock_not_38", locked, 0);
        prbs(1'b0, 0);
        chk("relock_at_39",      locked,    1);
        chk("relock_err_retain", err_count, 8);

        // Seven errors in each of two consecutive windows: lock holds.
        drops = 0;
        for (int w = 0; w < 2; w++) begin
            for (int j = 1; j <= 128; j++) begin
                prbs(((j % 16) == 0 && j <= 112) ? 1'b1 : 1'b0, 0);
                if (locked !== 1'b1) drops++;
            end
            chk("window_err_cnt", err_count, 32'(15 + 7 * w));
        end
        chk("window_no_drops", drops, 0);

        // Reset mid-operation takes effect without a clock edge.
        rst = 1'b1;
        #1;
        chk("async_rst_locked",  locked,    0);
        chk("async_rst_err_cnt", err_count, 0);
        chk("async_rst_bit_cnt", bit_count, 0);
        tick();
        rst = 1'b0;

        // Constant zeros then constant ones never lock.
        ever = 0;
        for (int i = 0; i < 500; i++) begin
            send(1'b0, 0);
            if (locked !== 1'b0) ever++;
        end
        chk("zeros_no_lock", ever, 0);
        ever = 0;
        for (int i = 0; i < 500; i++) begin
            send(1'b1, 0);
            if (locked !== 1'b0) ever++;
        end
        chk("ones_no_lock", ever, 0);

        // Fresh start after reset with irregular bit spacing.
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        tx_r = 7'h7F;
        for (int i = 0; i < 38; i++) prbs(1'b0, i % 3);
        chk("jit_no_lock_38", locked, 0);
        prbs(1'b0, 1);
        chk("jit_lock_39", locked, 1);
        drops = 0;
        for (int i = 0; i < 10000; i++) begin
            prbs(1'b0, (i * 7) % 3);
            if (locked !== 1'b1) drops++;
        end
        chk("jit_no_drops", drops,     0);
        chk("jit_err_cnt",  err_count, 0);
        chk("jit_bit_cnt",  bit_count, 10000);

        // Clear wins over a simultaneous error; the pulse still appears.
        clr_counts = 1'b1;
        prbs(1'b1, 0);
        clr_counts = 1'b0;
        chk("clr_prio_pulse",   bit_err,   1);
        chk("clr_prio_err_cnt", err_count, 0);
        chk("clr_prio_bit_cnt", bit_count, 0);
        chk("clr_prio_locked",  locked,    1);
        prbs(1'b0, 0);
        chk("after_clr_bit_cnt", bit_count, 1);
        chk("after_clr_err_cnt", err_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 32: consecutive matching bits required to declare lock.
REQ-002 Parameter LOSS_ERRS, default 8: errors within one window that force loss of lock.
REQ-003 Parameter LOSS_WINDOW, default 128: valid bits per error-monitoring window while locked.
REQ-004 clk_x8  input  1: single clock, the CDR oversampling clock; all logic on its rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 d_in  input  1: recovered data bit from clock_data_recovery d_out.
REQ-007 d_in_valid  input  1: qualifies d_in; exactly one bit is consumed per cycle with d_in_valid=1.
REQ-008 clr_counts  input  1: synchronous clear of err_count and bit_count.
REQ-009 locked  output  1: checker synchronised to the PRBS stream.
REQ-010 bit_err  output  1: one-cycle pulse per mismatched bit while locked.
REQ-011 err_count  output  16: saturating count of bit errors while locked.
REQ-012 bit_count  output  32: saturating count of valid bits checked while locked.

Function
REQ-013 The sequence SHALL be PRBS7, x^7+x^6+1, matching the tx block: 7-bit register r, predicted bit p = r[6]^r[5], shift is r <= {r[5:0], bit}.
REQ-014 The state machine SHALL have two states: HUNT and LOCKED.
REQ-015 In HUNT, on each valid bit, r SHALL shift in the received d_in.
REQ-016 In HUNT, the match counter SHALL increment when d_in==p and fill>=7, and SHALL clear on a mismatch; fill counts valid bits loaded since entering HUNT and saturates at 7.
REQ-017 In HUNT, a valid bit arriving while r==0 SHALL clear the match counter, so an all-zero line never locks.
REQ-018 HUNT SHALL go to LOCKED on the valid bit that brings the match counter to LOCK_COUNT; locked SHALL rise on the next clock edge.
REQ-019 In LOCKED, r SHALL shift in p rather than d_in, so the generator free-runs and bit errors do not propagate.
REQ-020 In LOCKED, each valid bit SHALL increment bit_count, and SHALL also increment the window bit counter.
REQ-021 In LOCKED, a valid bit with d_in!=p SHALL assert bit_err on the next edge for exactly one cycle, and SHALL increment err_count and the window error counter.
REQ-022 The window error count, including the current bit, SHALL be compared against LOSS_ERRS.
  - If it reaches LOSS_ERRS: the next state is HUNT, locked falls, fill, match counter and window counters clear, and r is retained.
REQ-023 When the window bit counter reaches LOSS_WINDOW without loss, both window counters SHALL clear.
REQ-024 err_count and bit_count SHALL saturate at all-ones, with no wrap, and SHALL hold their values on return to HUNT.
REQ-025 clr_counts SHALL zero both counters on the next edge.
  - It has priority over a simultaneous increment; that bit is not counted.
  - bit_err still pulses.
REQ-026 Cycles with d_in_valid=0 SHALL change no state or counter, and bit_err SHALL be 0 in them.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While rst=1, all of the following SHALL hold: state=HUNT, r=0, fill, match and window counters =0, locked=0, bit_err=0, err_count=0, bit_count=0.
REQ-029 Reset asserted mid-operation SHALL abort immediately; after release the first valid bit SHALL be treated as the first bit of HUNT.

Verification
REQ-030 Clean PRBS7, seed 7'h7F, every 8th cycle valid -> locked rises one edge after valid bit 39 (7 fill + 32 matches); err_count=0 after 1000 further bits; bit_count=1000.
REQ-031 Locked, invert one bit -> single bit_err pulse, err_count=1, locked remains 1; the following bits produce no further errors.
REQ-032 Locked, invert 8 bits within 128 -> locked falls after the 8th error; with a clean stream thereafter it relocks after 39 valid bits; err_count=8 is retained.
REQ-033 Locked, invert 7 bits in each of consecutive 128-bit windows -> locked stays 1, err_count increments by 7 per window.
REQ-034 Constant 0 input for 500 bits, then constant 1 for 500 bits -> locked never asserts for the zeros; ones satisfy p=1^1=0≠1, so no lock either.
REQ-035 The bench SHALL drive tx, then clock_data_recovery, then this block, with a 5% bit-clock mismatch -> locked asserts and stays 1; err_count=0 over 10000 bits; clr_counts pulse -> both counts 0 next edge.
